// File: rtl/vid_timing_pkg.sv
// Shared video timing helpers: FSM encoding, blanking totals and counter sizing.
package vid_timing_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_PRIME = ST_PRIME,
        S_RUN   = ST_RUN
    } state_t;

    function automatic int tot4(input int a, input int b, input int c, input int d);
        return a + b + c + d;
    endfunction

    // Bits needed to count 0..n-1; never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// Horizontal/vertical raster counters with active, hsync and vsync decode.
module vid_timing_cnt
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    localparam int H_TOT   = tot4(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOT   = tot4(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW      = clog2(H_TOT),
    localparam int VW      = clog2(V_TOT)
)(
    input  logic          rd_clk,
    input  logic          rd_rst,
    input  logic          run,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          de_int,
    output logic          hs_int,
    output logic          vs_int
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;

    // Counters sit at zero outside RUN so the first RUN cycle is pixel (0,0).
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    assign h_cnt  = r_h_cnt;
    assign v_cnt  = r_v_cnt;
    assign de_int = run && (32'(r_h_cnt) < H_ACTIVE) && (32'(r_v_cnt) < V_ACTIVE);
    assign hs_int = run && (32'(r_h_cnt) >= H_ACTIVE + H_FP)
                        && (32'(r_h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
    assign vs_int = run && (32'(r_v_cnt) >= V_ACTIVE + V_FP)
                        && (32'(r_v_cnt) <  V_ACTIVE + V_FP + V_SYNC);

endmodule

// File: rtl/vid_fifo_reader.sv
// Pulls pixels from a prefetch FIFO and emits registered raster timing with them.
module vid_fifo_reader
    import vid_timing_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int SYNC_POL = 1,
    localparam int H_TOT   = tot4(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOT   = tot4(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW      = clog2(H_TOT),
    localparam int VW      = clog2(V_TOT)
)(
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_vld,
    output logic              fifo_rd_en,
    output logic              hs_o,
    output logic              vs_o,
    output logic              de_o,
    output logic [DATA_W-1:0] pix_o,
    output logic              frame_start,
    output logic              underflow,
    output logic              busy
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic          SYNC_INACT = (SYNC_POL == 0);

    state_t            r_state;
    logic              r_de;
    logic              r_hs;
    logic              r_vs;
    logic [DATA_W-1:0] r_pix;
    logic              r_fs;
    logic              r_uf;

    logic              w_run;
    logic [HW-1:0]     w_h_cnt;
    logic [VW-1:0]     w_v_cnt;
    logic              w_de_int;
    logic              w_hs_int;
    logic              w_vs_int;
    logic              w_frame_end;

    assign w_run       = (r_state == S_RUN);
    assign w_frame_end = (w_h_cnt == H_LAST) && (w_v_cnt == V_LAST);

    vid_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_cnt (
        .rd_clk (rd_clk),
        .rd_rst (rd_rst),
        .run    (w_run),
        .h_cnt  (w_h_cnt),
        .v_cnt  (w_v_cnt),
        .de_int (w_de_int),
        .hs_int (w_hs_int),
        .vs_int (w_vs_int)
    );

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state <= S_IDLE;
            r_de    <= 1'b0;
            r_hs    <= SYNC_INACT;
            r_vs    <= SYNC_INACT;
            r_pix   <= '0;
            r_fs    <= 1'b0;
            r_uf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  if (enable) r_state <= S_PRIME;
                S_PRIME: begin
                    if (!enable)       r_state <= S_IDLE;
                    else if (fifo_vld) r_state <= S_RUN;
                end
                // Only leave at the very last pixel so a frame is never cut short.
                S_RUN:   if (w_frame_end && !enable) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            r_de  <= w_de_int;
            r_hs  <= w_hs_int ^ SYNC_INACT;
            r_vs  <= w_vs_int ^ SYNC_INACT;
            r_pix <= (w_de_int && fifo_vld) ? fifo_data : '0;
            r_fs  <= w_run && (w_h_cnt == '0) && (w_v_cnt == '0);
            if (w_de_int && !fifo_vld) r_uf <= 1'b1;
        end
    end

    // Pop strobe is the raw active flag; an empty FIFO never stalls the raster.
    assign fifo_rd_en  = w_de_int;
    assign hs_o        = r_hs;
    assign vs_o        = r_vs;
    assign de_o        = r_de;
    assign pix_o       = r_pix;
    assign frame_start = r_fs;
    assign underflow   = r_uf;
    assign busy        = (r_state == S_PRIME) || (r_state == S_RUN);

endmodule
